// File: rtl/simd_operand_streamer.sv
// simd_operand_streamer: buffers A/B operand pairs and replays entries 0..N-1
// as a burst into the SIMD core, with downstream hold, a done pulse and a
// wr_err pulse for host requests rejected while a burst is in flight.
//
// Handshake: hold is a stall request from the core. A hold sampled at an edge
// in STREAM turns the following cycle into a bubble (valid_data=0, opa/opb
// retain the last beat, index frozen). valid_data marks each cycle that
// carries a new beat. The streamer never waits on the core otherwise.
module simd_operand_streamer #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              start,
  input  logic [2:0]        start_instr,
  input  logic [ADDR_W-1:0] start_size,
  input  logic              hold,
  output logic              valid_instruction,
  output logic [2:0]        instruction,
  output logic [ADDR_W-1:0] data_size,
  output logic              valid_data,
  output logic [DATA_W-1:0] mc_data_in_opa,
  output logic [DATA_W-1:0] mc_data_in_opb,
  output logic              busy,
  output logic              done,
  output logic              wr_err,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, idx_next, idx_inc;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  logic              vi_n, vd_n, busy_n, done_n, wr_err_n;
  logic [2:0]        instr_n;
  logic [ADDR_W-1:0] size_n;
  logic [DATA_W-1:0] opa_n, opb_n;

  assign idx_inc   = idx + 1'b1;
  assign fsm_state = state;

  // Operand buffer: host writes land only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE) begin
      mem_a[wr_addr] <= wr_data_a;
      mem_b[wr_addr] <= wr_data_b;
    end
  end

  // Next-state, beat index and next values of every registered output.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    vi_n       = valid_instruction;
    instr_n    = instruction;
    size_n     = data_size;
    vd_n       = 1'b0;
    opa_n      = mc_data_in_opa;
    opb_n      = mc_data_in_opb;
    busy_n     = busy;
    done_n     = 1'b0;
    wr_err_n   = (state != S_IDLE) && (wr_en || start);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ISSUE;
          idx_next   = '0;
          vi_n       = 1'b1;
          instr_n    = start_instr;
          size_n     = start_size;
          busy_n     = 1'b1;
        end
      end
      S_ISSUE: begin
        // Beat 0; a same-cycle write with start has already landed.
        state_next = S_STREAM;
        vd_n       = 1'b1;
        opa_n      = mem_a[idx];
        opb_n      = mem_b[idx];
      end
      S_STREAM: begin
        if (hold) begin
          vd_n = 1'b0;
        end else if (idx == data_size) begin
          state_next = S_DONE;
          vi_n       = 1'b0;
          done_n     = 1'b1;
        end else begin
          idx_next = idx_inc;
          vd_n     = 1'b1;
          opa_n    = mem_a[idx_inc];
          opb_n    = mem_b[idx_inc];
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        busy_n     = 1'b0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, index and output registers; reset aborts any burst immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      idx               <= '0;
      valid_instruction <= 1'b0;
      instruction       <= '0;
      data_size         <= '0;
      valid_data        <= 1'b0;
      mc_data_in_opa    <= '0;
      mc_data_in_opb    <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      wr_err            <= 1'b0;
    end else begin
      state             <= state_next;
      idx               <= idx_next;
      valid_instruction <= vi_n;
      instruction       <= instr_n;
      data_size         <= size_n;
      valid_data        <= vd_n;
      mc_data_in_opa    <= opa_n;
      mc_data_in_opb    <= opb_n;
      busy              <= busy_n;
      done              <= done_n;
      wr_err            <= wr_err_n;
    end
  end

endmodule

// File: tb/tb_simd_operand_streamer.sv
// Directed bench for simd_operand_streamer: bursts, hold, busy rejection,
// mid-burst reset and write+start in the same cycle.
module tb_simd_operand_streamer;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk, reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data_a, wr_data_b;
  logic              start;
  logic [2:0]        start_instr;
  logic [ADDR_W-1:0] start_size;
  logic              hold;
  logic              valid_instruction;
  logic [2:0]        instruction;
  logic [ADDR_W-1:0] data_size;
  logic              valid_data;
  logic [DATA_W-1:0] mc_data_in_opa, mc_data_in_opb;
  logic              busy, done, wr_err;
  logic [1:0]        fsm_state;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0]   exp_a [DEPTH];
  logic [DATA_W-1:0]   exp_b [DEPTH];
  logic [2*DATA_W-1:0] exp_q [$];

  simd_operand_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .start(start), .start_instr(start_instr), .start_size(start_size), .hold(hold),
    .valid_instruction(valid_instruction), .instruction(instruction),
    .data_size(data_size), .valid_data(valid_data),
    .mc_data_in_opa(mc_data_in_opa), .mc_data_in_opb(mc_data_in_opb),
    .busy(busy), .done(done), .wr_err(wr_err), .fsm_state(fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat_a(input int i);
    logic [31:0] w;
    w = 32'(i) * 32'h11111111;
    return {4{w}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pair(input int addr, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data_a = a; wr_data_b = b;
    step();
    wr_en = 1'b0;
    exp_a[addr] = a;
    exp_b[addr] = b;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_vi"},   valid_instruction, 0);
    chk({tag, "_vd"},   valid_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_werr"}, wr_err, 0);
    chk({tag, "_opa"},  mc_data_in_opa, 0);
    chk({tag, "_opb"},  mc_data_in_opb, 0);
    chk({tag, "_size"}, data_size, 0);
    chk({tag, "_ins"},  instruction, 0);
  endtask

  // Start a burst and check every cycle through DONE and back to idle.
  // hold_at/hold_len: stall after that beat; inject: busy-time wr_en and start.
  task automatic run_burst(input logic [2:0] instr, input int size,
                           input int hold_at, input int hold_len, input bit inject);
    logic [2*DATA_W-1:0] cur;
    int k, stall;
    exp_q.delete();
    for (int i = 0; i <= size; i++) exp_q.push_back({exp_a[i], exp_b[i]});
    start = 1'b1; start_instr = instr; start_size = ADDR_W'(size);
    step();
    start = 1'b0; wr_en = 1'b0;
    chk("issue_vi", valid_instruction, 1);
    chk("issue_vd", valid_data, 0);
    chk("issue_ins", instruction, DATA_W'(instr));
    chk("issue_size", data_size, DATA_W'(size));
    chk("issue_busy", busy, 1);
    k = 0; stall = 0; cur = '0;
    for (int c = 0; c < size + 1 + hold_len; c++) begin
      step();
      if (stall > 0) begin
        chk("stall_vd", valid_data, 0);
        chk("stall_opa", mc_data_in_opa, cur[2*DATA_W-1:DATA_W]);
        stall--;
        if (stall == 0) hold = 1'b0;
      end else begin
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("beat_vd", valid_data, 1);
        chk("beat_vi", valid_instruction, 1);
        chk("beat_opa", mc_data_in_opa, cur[2*DATA_W-1:DATA_W]);
        chk("beat_opb", mc_data_in_opb, cur[DATA_W-1:0]);
        chk("beat_done", done, 0);
        if (k == hold_at) begin
          hold = 1'b1;
          stall = hold_len;
        end
        if (inject) begin
          if (k == 3) begin
            wr_en = 1'b1; wr_addr = 3; wr_data_a = '1; wr_data_b = '1;
          end else if (k == 4) begin
            wr_en = 1'b0;
            chk("rej_wr_err", wr_err, 1);
            start = 1'b1; start_size = 2; start_instr = 3'b111;
          end else if (k == 5) begin
            start = 1'b0;
            chk("rej_start_err", wr_err, 1);
          end else if (k == 6) begin
            chk("rej_err_clear", wr_err, 0);
          end
        end
        k++;
      end
    end
    chk("beat_count", k, size + 1);
    step();
    chk("done_pulse", done, 1);
    chk("done_vd", valid_data, 0);
    chk("done_vi", valid_instruction, 0);
    chk("done_busy", busy, 1);
    step();
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("after_ins", instruction, DATA_W'(instr));
    chk("after_size", data_size, DATA_W'(size));
    chk("after_opa", mc_data_in_opa, exp_a[size]);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data_a = '0; wr_data_b = '0;
    start = 1'b0; start_instr = '0; start_size = '0; hold = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk_idle_outputs("reset");
    step(); step();
    reset = 1'b0;
    step();
    chk_idle_outputs("post_reset");

    // 14-beat burst
    for (int i = 0; i < 14; i++) write_pair(i, pat_a(i), ~pat_a(i));
    run_burst(3'b000, 13, -1, 0, 1'b0);

    // single beat and full depth
    for (int i = 14; i < DEPTH; i++) write_pair(i, pat_a(i), ~pat_a(i));
    run_burst(3'b001, 0, -1, 0, 1'b0);
    run_burst(3'b010, 63, -1, 0, 1'b0);

    // hold for 3 cycles after beat 2
    run_burst(3'b011, 5, 2, 3, 1'b0);

    // rejected write to addr 3 and second start during a burst
    run_burst(3'b100, 13, -1, 0, 1'b1);
    run_burst(3'b101, 4, -1, 0, 1'b0);

    // reset during beat 7 of a 14-beat burst
    start = 1'b1; start_instr = 3'b110; start_size = 13;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("pre_rst_opa", mc_data_in_opa, exp_a[7]);
    reset = 1'b1;
    #2;
    chk_idle_outputs("mid_rst");
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_done", done, 0);
      chk("rst_no_busy", busy, 0);
    end
    run_burst(3'b000, 13, -1, 0, 1'b0);

    // write and start in the same idle cycle
    wr_en = 1'b1; wr_addr = 0;
    wr_data_a = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    wr_data_b = 128'h0f0f0f0f_a5a5a5a5_5a5a5a5a_f0f0f0f0;
    exp_a[0] = wr_data_a;
    exp_b[0] = wr_data_b;
    run_burst(3'b001, 2, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
